// File: rtl/des_byte_buffer.sv
// rtl/des_byte_buffer.sv - I2C byte <-> 64-bit DES block buffer
// RX side packs bytes MSB-first into blocks; TX side serialises result blocks.
module des_byte_buffer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        i2c_stop,
    output logic [63:0] des_in,
    output logic        data_ready,
    input  logic [63:0] des_out,
    input  logic        next_data,
    input  logic        tx_req,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        rx_partial,
    output logic        tx_underrun,
    output logic        tx_overrun
);

    typedef enum logic [1:0] {TX_EMPTY, TX_LOADED, TX_SEND} tx_state_t;

    logic [2:0]  cnt_q, cnt_d, cnt_inc;
    logic [63:0] asm_q, asm_d;
    logic [63:0] des_in_q, des_in_d;
    logic        data_ready_q, data_ready_d;
    logic        rx_partial_q, rx_partial_d;

    tx_state_t   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] buf_q, buf_d;
    logic        underrun_q, underrun_d;
    logic        overrun_q, overrun_d;

    // The byte is accepted before a coincident stop is considered, so a
    // completing byte wraps the counter to 0 and no partial is reported.
    always_comb begin
        cnt_inc      = rx_valid ? cnt_q + 3'd1 : cnt_q;
        cnt_d        = cnt_inc;
        asm_d        = asm_q;
        des_in_d     = des_in_q;
        data_ready_d = 1'b0;
        rx_partial_d = 1'b0;
        if (rx_valid) begin
            asm_d = {asm_q[55:0], rx_byte};
            if (cnt_q == 3'd7) begin
                des_in_d     = {asm_q[55:0], rx_byte};
                data_ready_d = 1'b1;
            end
        end
        if (i2c_stop && cnt_inc != 3'd0) begin
            cnt_d        = 3'd0;
            rx_partial_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        if (next_data) begin
            state_d   = TX_LOADED;
            idx_d     = 3'd0;
            buf_d     = des_out;
            overrun_d = (state_q != TX_EMPTY);
        end else begin
            case (state_q)
                TX_EMPTY: begin
                    underrun_d = tx_req;
                end
                TX_LOADED: begin
                    if (tx_req) begin
                        state_d = TX_SEND;
                        idx_d   = 3'd1;
                        buf_d   = {buf_q[55:0], 8'h00};
                    end
                end
                TX_SEND: begin
                    if (i2c_stop || (tx_req && idx_q == 3'd7)) begin
                        state_d = TX_EMPTY;
                        idx_d   = 3'd0;
                    end else if (tx_req) begin
                        idx_d = idx_q + 3'd1;
                        buf_d = {buf_q[55:0], 8'h00};
                    end
                end
                default: begin
                    state_d = TX_EMPTY;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q        <= 3'd0;
            asm_q        <= 64'h0;
            des_in_q     <= 64'h0;
            data_ready_q <= 1'b0;
            rx_partial_q <= 1'b0;
            state_q      <= TX_EMPTY;
            idx_q        <= 3'd0;
            buf_q        <= 64'h0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            des_in_q     <= des_in_d;
            data_ready_q <= data_ready_d;
            rx_partial_q <= rx_partial_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

    assign des_in      = des_in_q;
    assign data_ready  = data_ready_q;
    assign rx_partial  = rx_partial_q;
    assign tx_valid    = (state_q != TX_EMPTY);
    assign tx_byte     = tx_valid ? buf_q[63:56] : 8'hFF;
    assign tx_underrun = underrun_q;
    assign tx_overrun  = overrun_q;

endmodule

// File: tb/tb_des_byte_buffer.sv
// tb/tb_des_byte_buffer.sv - self-checking bench for des_byte_buffer
module tb_des_byte_buffer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        i2c_stop = 1'b0;
    logic [63:0] des_in;
    logic        data_ready;
    logic [63:0] des_out = 64'h0;
    logic        next_data = 1'b0;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        rx_partial;
    logic        tx_underrun;
    logic        tx_overrun;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    logic [63:0] m_des_in = 64'h0;
    bit          m_dr = 0, m_rp = 0, m_uo = 0, m_oo = 0;

    des_byte_buffer dut (
        .clk(clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .i2c_stop(i2c_stop), .des_in(des_in), .data_ready(data_ready),
        .des_out(des_out), .next_data(next_data), .tx_req(tx_req),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .rx_partial(rx_partial),
        .tx_underrun(tx_underrun), .tx_overrun(tx_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_tx_byte();
        return (m_tx.size() != 0) ? m_tx[0] : 8'hFF;
    endfunction

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        m_des_in = 64'h0;
        m_dr = 0; m_rp = 0; m_uo = 0; m_oo = 0;
    endtask

    // Reference behaviour: byte queues for the partial RX block and unread TX bytes.
    task automatic model_edge(input bit rxv, input logic [7:0] rxb, input bit stop,
                              input bit nd, input logic [63:0] dout, input bit treq);
        m_dr = 0; m_rp = 0; m_uo = 0; m_oo = 0;
        if (rxv) m_rx.push_back(rxb);
        if (m_rx.size() == 8) begin
            m_des_in = 64'h0;
            for (int i = 0; i < 8; i++) m_des_in = m_des_in | (64'(m_rx[i]) << (56 - 8 * i));
            m_rx.delete();
            m_dr = 1;
        end else if (stop && m_rx.size() != 0) begin
            m_rx.delete();
            m_rp = 1;
        end
        if (nd) begin
            if (m_tx.size() != 0) m_oo = 1;
            m_tx.delete();
            for (int i = 0; i < 8; i++) m_tx.push_back(dout[63 - 8 * i -: 8]);
        end else if (stop && m_tx.size() > 0 && m_tx.size() < 8) begin
            m_tx.delete();
        end else if (treq) begin
            if (m_tx.size() == 0) m_uo = 1;
            else void'(m_tx.pop_front());
        end
    endtask

    task automatic cycle(input bit rxv, input logic [7:0] rxb, input bit stop,
                         input bit nd, input logic [63:0] dout, input bit treq);
        rx_valid = rxv; rx_byte = rxb; i2c_stop = stop;
        next_data = nd; des_out = dout; tx_req = treq;
        @(posedge clk);
        model_edge(rxv, rxb, stop, nd, dout, treq);
        #1;
        rx_valid = 0; i2c_stop = 0; next_data = 0; tx_req = 0;
    endtask

    task automatic idle();
        cycle(0, 8'h00, 0, 0, 64'h0, 0);
    endtask

    task automatic test_reset();
        checks++; if (des_in !== 64'h0) begin failures++; $display("FAIL reset_des_in got=%h exp=0", des_in); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_byte !== 8'hFF) begin failures++; $display("FAIL reset_tx_byte got=%h exp=ff", tx_byte); end
        checks++; if ({rx_partial, tx_underrun, tx_overrun} !== 3'b000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=000", {rx_partial, tx_underrun, tx_overrun}); end
    endtask

    task automatic test_rx_block();
        logic [63:0] blk = 64'h1234567890abcdef;
        for (int i = 0; i < 8; i++) begin
            cycle(1, blk[63 - 8 * i -: 8], 0, 0, 64'h0, 0);
            if (i < 7) begin
                checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL rx_early_ready byte=%0d got=%b exp=0", i, data_ready); end
            end
        end
        checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL rx_ready got=%b exp=1", data_ready); end
        checks++; if (des_in !== 64'h1234567890abcdef) begin failures++; $display("FAIL rx_des_in got=%h exp=1234567890abcdef", des_in); end
        idle();
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL rx_ready_width got=%b exp=0", data_ready); end
    endtask

    task automatic test_rx_partial();
        logic [63:0] old = m_des_in;
        for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0, 64'h0, 0);
        cycle(0, 8'h00, 1, 0, 64'h0, 0);
        checks++; if (rx_partial !== 1'b1) begin failures++; $display("FAIL partial_pulse got=%b exp=1", rx_partial); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL partial_no_ready got=%b exp=0", data_ready); end
        checks++; if (des_in !== old) begin failures++; $display("FAIL partial_des_in got=%h exp=%h", des_in, old); end
        idle();
        checks++; if (rx_partial !== 1'b0) begin failures++; $display("FAIL partial_width got=%b exp=0", rx_partial); end
        for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0, 64'h0, 0);
        checks++; if (data_ready !== 1'b1 || des_in !== m_des_in) begin
            failures++; $display("FAIL partial_reassemble got=%b/%h exp=1/%h", data_ready, des_in, m_des_in); end
    endtask

    task automatic test_tx_read();
        cycle(0, 8'h00, 0, 1, 64'h1234567890abcdef, 0);
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_byte !== exp_tx_byte()) begin
                failures++; $display("FAIL tx_seq idx=%0d got=%b/%h exp=1/%h", i, tx_valid, tx_byte, exp_tx_byte()); end
            cycle(0, 8'h00, 0, 0, 64'h0, 1);
        end
        checks++; if (tx_valid !== 1'b0 || tx_byte !== 8'hFF) begin
            failures++; $display("FAIL tx_drained got=%b/%h exp=0/ff", tx_valid, tx_byte); end
    endtask

    task automatic test_underrun_overrun();
        logic [63:0] d2 = {$urandom, $urandom};
        cycle(0, 8'h00, 0, 0, 64'h0, 1);
        checks++; if (tx_underrun !== 1'b1 || tx_byte !== 8'hFF) begin
            failures++; $display("FAIL underrun got=%b/%h exp=1/ff", tx_underrun, tx_byte); end
        cycle(0, 8'h00, 0, 1, {$urandom, $urandom}, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 64'h0, 1);
        cycle(0, 8'h00, 0, 1, d2, 0);
        checks++; if (tx_overrun !== 1'b1) begin failures++; $display("FAIL overrun got=%b exp=1", tx_overrun); end
        checks++; if (tx_byte !== d2[63:56]) begin failures++; $display("FAIL overrun_restart got=%h exp=%h", tx_byte, d2[63:56]); end
        idle();
        checks++; if (tx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
            failures++; $display("FAIL overrun_width got=%b%b exp=00", tx_overrun, tx_underrun); end
    endtask

    task automatic test_coincident();
        logic [63:0] d3 = {$urandom, $urandom};
        while (m_tx.size() != 0) cycle(0, 8'h00, 0, 0, 64'h0, 1);
        for (int i = 0; i < 7; i++) cycle(1, 8'($urandom), 0, 0, 64'h0, 0);
        cycle(1, 8'h5A, 1, 0, 64'h0, 0);
        checks++; if (data_ready !== 1'b1 || rx_partial !== 1'b0) begin
            failures++; $display("FAIL stop_with_8th got=%b/%b exp=1/0", data_ready, rx_partial); end
        checks++; if (des_in !== m_des_in) begin failures++; $display("FAIL stop_with_8th_data got=%h exp=%h", des_in, m_des_in); end
        cycle(0, 8'h00, 0, 1, d3, 1);
        checks++; if (tx_byte !== d3[63:56] || tx_underrun !== 1'b0 || tx_overrun !== 1'b0) begin
            failures++; $display("FAIL load_with_req got=%h/%b/%b exp=%h/0/0", tx_byte, tx_underrun, tx_overrun, d3[63:56]); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0, 64'h0, 0);
        cycle(0, 8'h00, 0, 1, {$urandom, $urandom}, 0);
        cycle(0, 8'h00, 0, 0, 64'h0, 1);
        cycle(0, 8'h00, 0, 0, 64'h0, 1);
        #2 n_rst = 0;
        model_reset();
        #1;
        checks++; if (des_in !== 64'h0 || tx_valid !== 1'b0 || tx_byte !== 8'hFF) begin
            failures++; $display("FAIL async_reset got=%h/%b/%h exp=0/0/ff", des_in, tx_valid, tx_byte); end
        #2 n_rst = 1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++; if ({data_ready, rx_partial, tx_underrun, tx_overrun, tx_valid} !== 5'b0) begin
                failures++; $display("FAIL reset_release got=%b exp=00000", {data_ready, rx_partial, tx_underrun, tx_overrun, tx_valid}); end
        end
        for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0, 64'h0, 0);
        checks++; if (data_ready !== 1'b1 || des_in !== m_des_in) begin
            failures++; $display("FAIL reset_fresh_block got=%b/%h exp=1/%h", data_ready, des_in, m_des_in); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, {$urandom, $urandom}, $urandom_range(0, 9) < 4);
            checks++; if (des_in !== m_des_in || data_ready !== m_dr || rx_partial !== m_rp) begin
                failures++; $display("FAIL rand_rx n=%0d got=%h/%b/%b exp=%h/%b/%b", n, des_in, data_ready, rx_partial, m_des_in, m_dr, m_rp); end
            checks++; if (tx_valid !== (m_tx.size() != 0) || tx_byte !== exp_tx_byte()
                          || tx_underrun !== m_uo || tx_overrun !== m_oo) begin
                failures++; $display("FAIL rand_tx n=%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", n, tx_valid, tx_byte,
                                     tx_underrun, tx_overrun, m_tx.size() != 0, exp_tx_byte(), m_uo, m_oo); end
        end
    endtask

    initial begin
        model_reset();
        #12 n_rst = 1;
        @(posedge clk); #1;
        test_reset();
        test_rx_block();
        test_rx_partial();
        test_tx_read();
        test_underrun_overrun();
        test_coincident();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_byte_buffer.md
DES_BYTE_BUFFER -- requirements
Module: des_byte_buffer

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: n_rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: rx_byte  in  8  byte received from I2C slave.
REQ-004 SHALL have port: rx_valid  in  1  one-cycle strobe, rx_byte valid.
REQ-005 SHALL have port: i2c_stop  in  1  one-cycle strobe, I2C stop condition detected.
REQ-006 SHALL have port: des_in  out  64  assembled plaintext/ciphertext block to DES controller.
REQ-007 SHALL have port: data_ready  out  1  one-cycle pulse, des_in holds a new block.
REQ-008 SHALL have port: des_out  in  64  result block from DES controller.
REQ-009 SHALL have port: next_data  in  1  one-cycle strobe, des_out valid.
REQ-010 SHALL have port: tx_req  in  1  one-cycle strobe, I2C slave requests next read byte.
REQ-011 SHALL have port: tx_byte  out  8  byte to I2C slave for master read.
REQ-012 SHALL have port: tx_valid  out  1  tx_byte holds unread result data.
REQ-013 SHALL have port: rx_partial  out  1  one-cycle pulse, incomplete write block discarded.
REQ-014 SHALL have port: tx_underrun  out  1  one-cycle pulse, tx_req with no data.
REQ-015 SHALL have port: tx_overrun  out  1  one-cycle pulse, unread result overwritten.

Function
REQ-016 RX side SHALL keep a 3-bit byte counter (0-7) and a 64-bit assembly register separate from the des_in output register.
REQ-017 Bytes SHALL pack MSB-first: 1st rx byte -> des_in[63:56], 8th -> des_in[7:0].
REQ-018 On the 8th rx_valid, the full block SHALL transfer to des_in at that edge, the counter SHALL wrap to 0, and data_ready SHALL be high for exactly the following cycle.
REQ-019 des_in SHALL hold its value until the next completed block; partial reception SHALL NOT disturb it.
REQ-020 i2c_stop with RX counter != 0 SHALL clear the counter, discard the partial block, suppress data_ready, and pulse rx_partial the next cycle.
REQ-021 i2c_stop and rx_valid in the same cycle: byte SHALL be accepted first; if it completes a block, data_ready pulses and rx_partial does not.
REQ-022 TX side SHALL be an FSM with states TX_EMPTY (tx_valid=0), TX_LOADED (block captured, 0 bytes read), TX_SEND (1-7 bytes read).
REQ-023 next_data in any state SHALL capture des_out, set the TX index to 0, go to TX_LOADED; tx_byte = des_out[63:56] the next cycle.
REQ-024 next_data in TX_LOADED or TX_SEND SHALL additionally pulse tx_overrun the next cycle.
REQ-025 tx_req in TX_LOADED/TX_SEND SHALL advance the index; tx_byte SHALL present the next byte (MSB-first) the following cycle; the 8th tx_req SHALL return to TX_EMPTY.
REQ-026 tx_byte SHALL equal 8'hFF whenever tx_valid=0.
REQ-027 tx_req in TX_EMPTY SHALL leave state unchanged and pulse tx_underrun the next cycle.
REQ-028 next_data and tx_req in the same cycle: load SHALL win, tx_req SHALL be ignored, no underrun.
REQ-029 i2c_stop in TX_SEND SHALL discard remaining bytes and go to TX_EMPTY; in TX_LOADED it SHALL have no effect; next_data with i2c_stop SHALL load.
REQ-030 RX and TX sides SHALL operate independently and concurrently; i2c_stop applies to both in the same cycle.
REQ-031 All pulse outputs SHALL be registered, one cycle wide.

Reset
REQ-032 n_rst low SHALL immediately force: RX counter 0, des_in 64'h0, data_ready 0, TX state TX_EMPTY, tx_valid 0, tx_byte 8'hFF, rx_partial/tx_underrun/tx_overrun 0.
REQ-033 Reset mid-block SHALL discard the partial RX block and any unread TX data; no pulse SHALL be generated on release.

Verification
REQ-034 8 rx_valid strobes with bytes 12,34,56,78,90,AB,CD,EF -> des_in=64'h1234567890abcdef, data_ready high exactly one cycle after 8th strobe.
REQ-035 3 rx bytes then i2c_stop -> rx_partial one-cycle pulse, no data_ready, des_in unchanged; next 8 bytes assemble correctly from byte 0.
REQ-036 next_data with des_out=64'h1234567890abcdef, 8 tx_req -> tx_byte sequence 12,34,...,EF, tx_valid low and tx_byte=FF after 8th.
REQ-037 tx_req while empty -> tx_underrun pulse, tx_byte=FF; next_data during TX_SEND (after 3 reads) -> tx_overrun pulse, tx_byte restarts at new MSB byte.
REQ-038 8th rx_valid coincident with i2c_stop -> data_ready pulse, no rx_partial; same-cycle next_data+tx_req -> tx_byte=new MSB byte, no underrun.
REQ-039 n_rst asserted after 5 rx bytes and 2 tx reads -> all outputs at reset values asynchronously; no pulses after release.
